ads1672_serial_rx: RTL and testbench

ADS1672_SERIAL_RX -- requirements
Module: ads1672_serial_rx

---
 rtl/ads1672_serial_rx.sv | 158 +++++++++++++++
 tb/tb_ads1672_serial_rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ads1672_serial_rx.sv
// Serial receiver for the ADS1672 frame-sync data port: generates clkx/start,
// assembles MSB-first frames and buffers samples in a small FWFT FIFO.
module ads1672_serial_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int CLK_DIV     = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_PER = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  clkx,
  output logic                  start,
  input  logic                  fsr,
  input  logic                  drr,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  overflow,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BCW  = $clog2(DATA_WIDTH + 1);
  localparam int TOW  = $clog2(TIMEOUT_PER + 1);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, START, WAIT_FS, SHIFT, PUSH} state_e;

  state_e                state_q;
  logic [DIVW-1:0]       div_q;
  logic                  clkx_q, rise_q, fall_q, start_q, tmo_q;
  logic [BCW-1:0]        bit_q;
  logic [TOW-1:0]        to_q;
  logic [DATA_WIDTH-1:0] sh_q;

  // rise_q/fall_q flag the first cycle in which clkx shows its new level
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      clkx_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      tmo_q   <= 1'b0;
      bit_q   <= '0;
      to_q    <= '0;
      sh_q    <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (state_q != IDLE) begin
        if (div_q == DIVW'(CLK_DIV - 1)) begin
          div_q  <= '0;
          clkx_q <= ~clkx_q;
          rise_q <= ~clkx_q;
          fall_q <= clkx_q;
        end else begin
          div_q <= div_q + DIVW'(1);
        end
      end
      case (state_q)
        IDLE: if (enable) begin
          state_q <= START;
          start_q <= 1'b1;
        end
        START: if (fall_q) begin
          start_q <= 1'b0;
          to_q    <= '0;
          state_q <= WAIT_FS;
        end
        WAIT_FS: if (fall_q) begin
          if (!fsr) begin
            sh_q    <= {{(DATA_WIDTH-1){1'b0}}, drr};
            bit_q   <= BCW'(1);
            state_q <= SHIFT;
          end else if (to_q == TOW'(TIMEOUT_PER - 1)) begin
            tmo_q   <= 1'b1;
            state_q <= IDLE;
            div_q   <= '0;
            clkx_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
          end else begin
            to_q <= to_q + TOW'(1);
          end
        end
        SHIFT: if (fall_q) begin
          sh_q  <= {sh_q[DATA_WIDTH-2:0], drr};
          bit_q <= bit_q + BCW'(1);
          if (bit_q == BCW'(DATA_WIDTH - 1)) state_q <= PUSH;
        end
        PUSH: begin
          if (enable) begin
            state_q <= START;
            start_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            div_q   <= '0;
            clkx_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FWFT sample buffer; hold_q keeps the last delivered word while empty
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] hold_q;
  logic [AW-1:0]         wr_q, rd_q;
  logic [AW:0]           cnt_q;
  logic                  ovf_q, push, pop, full, wr_en;

  assign push  = (state_q == PUSH);
  assign pop   = m_valid && m_ready;
  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      hold_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop) begin
        rd_q   <= rd_q + AW'(1);
        hold_q <= mem_q[rd_q];
      end
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_q] <= sh_q;
  end

  assign m_valid     = (cnt_q != '0);
  assign m_data      = m_valid ? mem_q[rd_q] : hold_q;
  assign clkx        = clkx_q;
  assign start       = start_q;
  assign overflow    = ovf_q;
  assign timeout_err = tmo_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ads1672_serial_rx.sv
// Bench for ads1672_serial_rx: behavioural ADC on the serial port, scoreboard
// of expected samples checked at the consumer handshake.
module tb_ads1672_serial_rx;
  localparam int W = 24;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, m_ready = 1'b1;
  logic drr = 1'b0, fsr_m = 1'b1, fsr_tie = 1'b0, fsr;
  logic clkx, start, m_valid, overflow, timeout_err, busy;
  logic [W-1:0] m_data;

  assign fsr = fsr_m | fsr_tie;

  always #5 clk = ~clk;

  ads1672_serial_rx #(.DATA_WIDTH(W), .CLK_DIV(4), .FIFO_DEPTH(4), .TIMEOUT_PER(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clkx(clkx), .start(start),
    .fsr(fsr), .drr(drr), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .overflow(overflow), .timeout_err(timeout_err), .busy(busy)
  );

  int checks = 0, failures = 0;
  logic [W-1:0] adc_q[$], sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ADC model + output monitor, all observation on the falling clk edge
  int cyc = 0, last_fall = 0, vhigh = 0, pops = 0, start_rises = 0;
  int lsb_cnt = 0, bits_sent = 0, frames = 0, arm_cnt = 0, bi = 0;
  bit armed = 0, shifting = 0, lsb_pend = 0;
  logic pclkx = 1'b0, pvalid = 1'b0;
  logic [W-1:0] cur = '0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      armed = 0; shifting = 0; lsb_pend = 0; fsr_m = 1'b1; pvalid = 1'b0;
    end else begin
      if (clkx && !pclkx) begin
        if (start) begin
          start_rises++; armed = 1; arm_cnt = 0;
        end else if (armed) begin
          arm_cnt++;
          if (arm_cnt == 2) begin
            armed = 0;
            cur = (adc_q.size() != 0) ? adc_q.pop_front() : 24'hCACF0C;
            fsr_m = 1'b0; drr = cur[W-1]; bi = W - 2;
            bits_sent = 1; shifting = 1; frames++;
          end
        end else if (shifting) begin
          fsr_m = 1'b1; drr = cur[bi]; bits_sent++;
          if (bi == 0) begin shifting = 0; lsb_pend = 1; end
          else bi--;
        end
      end
      if (!clkx && pclkx) begin
        last_fall = cyc;
        if (lsb_pend) begin lsb_pend = 0; lsb_cnt++; end
      end
      if (m_valid && !pvalid) chk("latency", cyc - last_fall, 2);
      if (m_valid) vhigh++;
      if (m_valid && m_ready) begin
        pops++;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected: got %h expected none", m_data);
        end else begin
          chk("sb_data", m_data, sb.pop_front());
        end
      end
      pvalid = m_valid;
    end
    pclkx = clkx;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_start();
    for (int n = 0; n < 2000 && !start; n++) tick();
    chk("start_seen", start, 1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 5000 && busy; n++) tick();
    chk("idle_reached", busy, 0);
  endtask

  typedef struct { logic [W-1:0] word; logic [W-1:0] exp; } vec_t;
  vec_t vecs[5];
  logic [W-1:0] ov[6];
  logic [W-1:0] pp[5];

  initial begin
    int s0, v0, p0, l0, f0, falls, quiet;
    logic prev;
    vecs[0] = '{24'hCACF0C, 24'hCACF0C};
    vecs[1] = '{24'h000000, 24'h000000};
    vecs[2] = '{24'hFFFFFF, 24'hFFFFFF};
    vecs[3] = '{24'h800001, 24'h800001};
    vecs[4] = '{24'h5A5A5A, 24'h5A5A5A};
    ov = '{24'hCACF0C, 24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555};
    pp = '{24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 24'h0D0D0D, 24'h0E0E0E};

    repeat (3) tick();
    chk("rst_outs", {clkx, start, busy, m_valid, overflow, timeout_err}, 0);
    chk("rst_data", m_data, 0);
    reset = 1'b0;
    tick();

    // single frames, enable dropped once the conversion has started
    for (int i = 0; i < 5; i++) begin
      sb.push_back(vecs[i].exp);
      adc_q.push_back(vecs[i].word);
      s0 = start_rises; v0 = vhigh;
      enable = 1'b1;
      wait_start();
      enable = 1'b0;
      wait_idle();
      repeat (5) tick();
      chk("frame_delivered", sb.size(), 0);
      chk("valid_cycles", vhigh - v0, 1);
      chk("start_rises", start_rises - s0, 1);
    end

    // overflow: five frames into a four-deep buffer, sixth start still issued
    m_ready = 1'b0;
    for (int k = 0; k < 6; k++) adc_q.push_back(ov[k]);
    for (int k = 0; k < 4; k++) sb.push_back(ov[k]);
    s0 = start_rises;
    enable = 1'b1;
    for (int n = 0; n < 10000 && (start_rises - s0) < 6; n++) tick();
    chk("sixth_start", start_rises - s0, 6);
    chk("overflow_set", overflow, 1);
    chk("full_valid", m_valid, 1);
    enable = 1'b0;
    wait_idle();
    chk("head_oldest", m_data, 24'hCACF0C);
    p0 = pops;
    m_ready = 1'b1;
    repeat (10) tick();
    chk("drain_pops", pops - p0, 4);
    chk("empty_valid", m_valid, 0);
    chk("hold_data", m_data, 24'h333333);
    chk("overflow_sticky", overflow, 1);

    // full buffer with a pop in the PUSH cycle
    reset = 1'b1; tick(); reset = 1'b0; tick();
    adc_q.delete();
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin adc_q.push_back(pp[k]); sb.push_back(pp[k]); end
    s0 = start_rises; l0 = lsb_cnt;
    enable = 1'b1;
    for (int n = 0; n < 10000 && (start_rises - s0) < 5; n++) tick();
    enable = 1'b0;
    for (int n = 0; n < 2000 && (lsb_cnt - l0) < 5; n++) tick();
    chk("fifth_lsb", lsb_cnt - l0, 5);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("no_ovf_push_pop", overflow, 0);
    wait_idle();
    p0 = pops;
    m_ready = 1'b1;
    repeat (10) tick();
    chk("occupancy", pops - p0, 4);
    chk("pushpop_drained", sb.size(), 0);

    // no frame sync: timeout after eight WAIT_FS falls
    fsr_tie = 1'b1;
    v0 = vhigh;
    enable = 1'b1;
    wait_start();
    enable = 1'b0;
    falls = 0; prev = clkx;
    for (int n = 0; n < 5000 && falls < 9; n++) begin
      tick();
      if (prev && !clkx) falls++;
      prev = clkx;
    end
    chk("timeout_not_early", timeout_err, 0);
    chk("busy_before_to", busy, 1);
    tick();
    chk("timeout_set", timeout_err, 1);
    chk("busy_after_to", busy, 0);
    chk("clkx_after_to", clkx, 0);
    repeat (300) tick();
    chk("no_valid_on_to", vhigh - v0, 0);
    fsr_tie = 1'b0;
    chk("timeout_sticky", timeout_err, 1);

    // reset mid-frame discards the partial word
    reset = 1'b1; tick(); reset = 1'b0; tick();
    adc_q.delete();
    adc_q.push_back(24'h123456);
    f0 = frames;
    enable = 1'b1;
    for (int n = 0; n < 3000 && !(frames > f0 && bits_sent >= 11); n++) tick();
    enable = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_outs", {clkx, start, busy, m_valid, overflow, timeout_err}, 0);
    chk("midrst_data", m_data, 0);
    sb.push_back(24'hCACF0C); adc_q.push_back(24'hCACF0C);
    enable = 1'b1;
    wait_start();
    enable = 1'b0;
    wait_idle();
    repeat (5) tick();
    chk("post_rst_sample", sb.size(), 0);

    // enable dropped mid-frame: frame completes, then quiet IDLE
    adc_q.push_back(24'h5C3A91); sb.push_back(24'h5C3A91);
    f0 = frames;
    enable = 1'b1;
    for (int n = 0; n < 3000 && !(frames > f0 && bits_sent >= 6); n++) tick();
    enable = 1'b0;
    wait_idle();
    repeat (5) tick();
    chk("late_drop_sample", sb.size(), 0);
    s0 = start_rises; quiet = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (clkx || start || busy) quiet++;
    end
    chk("idle_quiet", quiet, 0);
    chk("no_more_start", start_rises - s0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
